instruction_encoder: RTL and testbench
======================================

Name: instruction_encoder

Overview:
- Reverse of the instruction decoder: takes a mnemonic ID plus operand fields and assembles 32-bit MIPS-I instruction words.
- Buffers the words in a small FIFO and streams them into instruction memory through a write port with backpressure, at an auto-incrementing word address.
- Used as the program loader / self-test stimulus source in front of instruction memory.

Parameters:
- AW, 10, instruction-memory word-address width.
- DEPTH, 4, FIFO depth in words; power of two, minimum 2.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  instruction request valid.
- in_ready  out  1  encoder can accept a request.
- in_mnem  in  6  mnemonic ID from the shared package.
- in_rs, in_rt, in_rd  in  5 each  register fields.
- in_shamt  in  5  shift amount.
- in_imm  in  16  immediate / branch offset.
- in_target  in  26  jump target.
- load_base  in  1  load the address counter from base_addr.
- base_addr  in  AW  new base word address.
- imem_we  out  1  write request to instruction memory.
- imem_ready  in  1  memory accepts the write.
- imem_addr  out  AW  word address.
- imem_wdata  out  32  encoded instruction.
- illegal_cnt  out  8  saturating count of rejected mnemonics.
- idle  out  1  FIFO empty and no write pending.

Behaviour:
- Reset values:
  - FIFO empty, imem_we=0, imem_addr=0, imem_wdata=0, illegal_cnt=0, idle=1.
  - in_ready=1 one cycle after reset release.
  - Reset mid-operation flushes all words; none are written afterwards.
- Input accept:
  - Handshake is in_valid & in_ready on a rising edge.
  - in_ready = !fifo_full. It has no combinational dependency on in_valid or imem_ready, and no full-FIFO bypass.
- Encoding (combinational from the inputs; result pushed on the accepting edge):
  - R-type: op=0, {rs,rt,rd,shamt,func}.
  - SLL/SRL/SRA: rs field forced 0.
  - Other R-type ops: shamt forced 0.
  - MULT/MULTU/DIV/DIVU: rd field forced 0.
  - I-type: {op,rs,rt,imm}.
  - LUI: rs forced 0.
  - BLEZ/BGTZ: rt forced 0.
  - REGIMM (op=1): rt forced to BLTZ 00000, BGEZ 00001, BLTZAL 10000, BGEZAL 10001.
  - J/JAL: {op,target}.
- Illegal mnemonic (ID outside the table):
  - Still handshaken so the input never deadlocks.
  - Not pushed into the FIFO.
  - illegal_cnt increments and saturates at 255.
- Output side:
  - First-word-fall-through; minimum latency is 1 cycle (accept on edge N, imem_we=1 after edge N).
  - imem_wdata and imem_addr hold stable while imem_we & !imem_ready.
  - On imem_we & imem_ready: pop the FIFO and increment imem_addr by 1, wrapping modulo 2^AW.
- Simultaneous push and pop in the same cycle: allowed; occupancy is unchanged.
- load_base:
  - On the edge it is sampled, imem_addr <= base_addr.
  - If it coincides with a completing write, that write uses the old address; the next word uses base_addr.
  - Pending FIFO contents are retained.
- idle = FIFO empty.

Decomposition:
- Shared package holds:
  - Opcode and func constants, the same values the decoder uses.
  - REGIMM rt codes.
  - The mnemonic-ID enumeration, IDs 0..45: ADD, ADDU, SUB, SUBU, AND, OR, XOR, NOR, SLT, SLTU, SLL, SRL, SRA, SLLV, SRLV, SRAV, MULT, MULTU, DIV, DIVU, ADDI, ADDIU, ANDI, ORI, XORI, SLTI, SLTIU, LUI, LB, LBU, LH, LHU, LW, SB, SH, SW, BEQ, BNE, BLEZ, BGTZ, BLTZ, BGEZ, BLTZAL, BGEZAL, J, JAL.
  - IDs 46..63 are illegal.
- One sub-module: instr_fifo, a synchronous FWFT FIFO parameterised by width and DEPTH, with full/empty flags.
- The encoder logic stays in the top level.

Test Plan:
- Single words, encoding and latency:
  - ADD rd=3 rs=1 rt=2 -> imem_wdata=0x00221820 at imem_addr=0, imem_we one cycle after accept.
  - ADDI rt=8 rs=0 imm=0x0005 -> 0x20080005 at addr 1.
- Forced fields:
  - SLL rd=2 rt=1 shamt=4 with rs=7 -> 0x00011100 (rs ignored).
  - BGEZAL rs=4 imm=0xFFFE with rt=9 -> 0x0491FFFE.
  - J target=0x100 -> 0x08000100.
- Backpressure:
  - Hold imem_ready=0 and push DEPTH+2 requests -> in_ready drops after DEPTH accepts; data and address stay stable.
  - Release imem_ready -> words drain in order at consecutive addresses, none lost or duplicated.
- Illegal mnemonic and saturation:
  - Mnemonic 50 -> accepted, no imem_we, illegal_cnt=1.
  - 300 illegal requests -> illegal_cnt=255.
- Base load and wrap:
  - load_base with base_addr=2^AW-1, then two words -> written at addresses 2^AW-1, then 0.
  - load_base coincident with a completing write -> that write uses the old address, the next uses base.
- Reset mid-stream:
  - Assert reset_n=0 with 3 words queued -> imem_we=0 immediately, imem_addr=0, illegal_cnt=0, idle=1.
  - No stale writes after release.

Source files
------------

// File: rtl/instruction_encoder_pkg.sv
// Shared MIPS-I encoding constants and the mnemonic-ID table.
// Opcode/func values match the instruction decoder bit for bit.
// Also holds small helpers that pack the three instruction formats.
package instruction_encoder_pkg;

   localparam int MNEM_W = 6;

   // Primary opcodes
   localparam logic [5:0] OP_SPECIAL = 6'h00, OP_REGIMM = 6'h01, OP_J    = 6'h02, OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ     = 6'h04, OP_BNE    = 6'h05, OP_BLEZ = 6'h06, OP_BGTZ  = 6'h07;
   localparam logic [5:0] OP_ADDI    = 6'h08, OP_ADDIU  = 6'h09, OP_SLTI = 6'h0A, OP_SLTIU = 6'h0B;
   localparam logic [5:0] OP_ANDI    = 6'h0C, OP_ORI    = 6'h0D, OP_XORI = 6'h0E, OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LB      = 6'h20, OP_LH     = 6'h21, OP_LW   = 6'h23, OP_LBU   = 6'h24;
   localparam logic [5:0] OP_LHU     = 6'h25, OP_SB     = 6'h28, OP_SH   = 6'h29, OP_SW    = 6'h2B;

   // SPECIAL func codes
   localparam logic [5:0] FN_SLL  = 6'h00, FN_SRL   = 6'h02, FN_SRA  = 6'h03, FN_SLLV = 6'h04;
   localparam logic [5:0] FN_SRLV = 6'h06, FN_SRAV  = 6'h07, FN_MULT = 6'h18, FN_MULTU = 6'h19;
   localparam logic [5:0] FN_DIV  = 6'h1A, FN_DIVU  = 6'h1B, FN_ADD  = 6'h20, FN_ADDU = 6'h21;
   localparam logic [5:0] FN_SUB  = 6'h22, FN_SUBU  = 6'h23, FN_AND  = 6'h24, FN_OR   = 6'h25;
   localparam logic [5:0] FN_XOR  = 6'h26, FN_NOR   = 6'h27, FN_SLT  = 6'h2A, FN_SLTU = 6'h2B;

   // REGIMM selectors carried in the rt field
   localparam logic [4:0] RT_BLTZ = 5'b00000, RT_BGEZ = 5'b00001, RT_BLTZAL = 5'b10000, RT_BGEZAL = 5'b10001;

   // Mnemonic IDs 0..45; anything from 46 up is illegal
   typedef enum logic [MNEM_W-1:0] {
      M_ADD, M_ADDU, M_SUB, M_SUBU, M_AND, M_OR, M_XOR, M_NOR, M_SLT, M_SLTU,
      M_SLL, M_SRL, M_SRA, M_SLLV, M_SRLV, M_SRAV, M_MULT, M_MULTU, M_DIV, M_DIVU,
      M_ADDI, M_ADDIU, M_ANDI, M_ORI, M_XORI, M_SLTI, M_SLTIU, M_LUI,
      M_LB, M_LBU, M_LH, M_LHU, M_LW, M_SB, M_SH, M_SW,
      M_BEQ, M_BNE, M_BLEZ, M_BGTZ, M_BLTZ, M_BGEZ, M_BLTZAL, M_BGEZAL, M_J, M_JAL
   } mnem_e;

   function automatic logic [31:0] r_word(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [4:0] sh,
                                          input logic [5:0] fn);
      return {OP_SPECIAL, rs, rt, rd, sh, fn};
   endfunction

   function automatic logic [31:0] i_word(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   function automatic logic [31:0] j_word(input logic [5:0] op, input logic [25:0] tgt);
      return {op, tgt};
   endfunction

endpackage

// File: rtl/instruction_encoder_if.sv
// Request bus into the encoder plus its instruction-memory write port.
// master = host/memory side, slave = the encoder.
// Word address width follows the memory (AW).
interface instruction_encoder_if #(
   parameter int AW = 10
);
   import instruction_encoder_pkg::*;

   logic              in_valid;
   logic              in_ready;
   logic [MNEM_W-1:0] in_mnem;
   logic [4:0]        in_rs;
   logic [4:0]        in_rt;
   logic [4:0]        in_rd;
   logic [4:0]        in_shamt;
   logic [15:0]       in_imm;
   logic [25:0]       in_target;
   logic              imem_we;
   logic              imem_ready;
   logic [AW-1:0]     imem_addr;
   logic [31:0]       imem_wdata;

   modport master (
      output in_valid, in_mnem, in_rs, in_rt, in_rd, in_shamt, in_imm, in_target, imem_ready,
      input  in_ready, imem_we, imem_addr, imem_wdata
   );

   modport slave (
      input  in_valid, in_mnem, in_rs, in_rt, in_rd, in_shamt, in_imm, in_target, imem_ready,
      output in_ready, imem_we, imem_addr, imem_wdata
   );

endinterface

// File: rtl/instruction_encoder_fifo.sv
// Synchronous first-word-fall-through FIFO with full/empty flags.
// Latency: a pushed word is visible at pop_dat_o the cycle after the push edge.
// Backpressure: push ignored while full, pop ignored while empty; push+pop keeps occupancy.
module instr_fifo #(
   parameter int W     = 32,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         push_i,
   input  logic [W-1:0] push_dat_i,
   input  logic         pop_i,
   output logic [W-1:0] pop_dat_o,
   output logic         full_o,
   output logic         empty_o
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = PW + 1;

   logic [W-1:0]  mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          do_push, do_pop;

   assign full_o    = (cnt_q == CW'(DEPTH));
   assign empty_o   = (cnt_q == '0);
   assign do_push   = push_i & ~full_o;
   assign do_pop    = pop_i & ~empty_o;
   assign pop_dat_o = mem_q[rd_ptr_q];

   // Pointer and occupancy next-state; pointers wrap naturally since DEPTH is a power of two
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (do_push & ~do_pop)      cnt_d = cnt_q + 1'b1;
      else if (do_pop & ~do_push) cnt_d = cnt_q - 1'b1;
   end

   // Control state; reset empties the FIFO
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // Storage needs no reset: it is never observed while empty
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
   end

endmodule

// File: rtl/instruction_encoder.sv
// Assembles MIPS-I words from mnemonic+fields and streams them to imem at an auto-incrementing address.
// Latency: 1 cycle from accept edge to imem_we (FWFT FIFO in between).
// Backpressure: in_ready = !fifo_full; imem_we held with stable addr/data until imem_ready.
module instruction_encoder
   import instruction_encoder_pkg::*;
#(
   parameter int AW    = 10,
   parameter int DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 reset_n,
   instruction_encoder_if.slave bus,
   input  logic                 load_base,
   input  logic [AW-1:0]        base_addr,
   output logic [7:0]           illegal_cnt,
   output logic                 idle
);
   logic [31:0]   enc_word, head_dat;
   logic          enc_legal, accept, push, pop, fifo_full, fifo_empty;
   logic [AW-1:0] addr_q, addr_d;
   logic [7:0]    illegal_q, illegal_d;
   logic [4:0]    rs, rt, rd, sh;
   logic [15:0]   imm;

   assign rs  = bus.in_rs;
   assign rt  = bus.in_rt;
   assign rd  = bus.in_rd;
   assign sh  = bus.in_shamt;
   assign imm = bus.in_imm;

   // Illegal mnemonics are still handshaken so the source never stalls on them
   assign bus.in_ready   = ~fifo_full;
   assign accept         = bus.in_valid & ~fifo_full;
   assign push           = accept & enc_legal;
   assign pop            = ~fifo_empty & bus.imem_ready;
   assign bus.imem_we    = ~fifo_empty;
   assign bus.imem_wdata = fifo_empty ? '0 : head_dat;
   assign bus.imem_addr  = addr_q;
   assign illegal_cnt    = illegal_q;
   assign idle           = fifo_empty;

   // Field packing per mnemonic, with the architecturally-zero fields forced
   always_comb begin
      enc_word  = '0;
      enc_legal = 1'b1;
      case (bus.in_mnem)
         M_ADD:    enc_word = r_word(rs, rt, rd, 5'd0, FN_ADD);
         M_ADDU:   enc_word = r_word(rs, rt, rd, 5'd0, FN_ADDU);
         M_SUB:    enc_word = r_word(rs, rt, rd, 5'd0, FN_SUB);
         M_SUBU:   enc_word = r_word(rs, rt, rd, 5'd0, FN_SUBU);
         M_AND:    enc_word = r_word(rs, rt, rd, 5'd0, FN_AND);
         M_OR:     enc_word = r_word(rs, rt, rd, 5'd0, FN_OR);
         M_XOR:    enc_word = r_word(rs, rt, rd, 5'd0, FN_XOR);
         M_NOR:    enc_word = r_word(rs, rt, rd, 5'd0, FN_NOR);
         M_SLT:    enc_word = r_word(rs, rt, rd, 5'd0, FN_SLT);
         M_SLTU:   enc_word = r_word(rs, rt, rd, 5'd0, FN_SLTU);
         M_SLL:    enc_word = r_word(5'd0, rt, rd, sh, FN_SLL);
         M_SRL:    enc_word = r_word(5'd0, rt, rd, sh, FN_SRL);
         M_SRA:    enc_word = r_word(5'd0, rt, rd, sh, FN_SRA);
         M_SLLV:   enc_word = r_word(rs, rt, rd, 5'd0, FN_SLLV);
         M_SRLV:   enc_word = r_word(rs, rt, rd, 5'd0, FN_SRLV);
         M_SRAV:   enc_word = r_word(rs, rt, rd, 5'd0, FN_SRAV);
         M_MULT:   enc_word = r_word(rs, rt, 5'd0, 5'd0, FN_MULT);
         M_MULTU:  enc_word = r_word(rs, rt, 5'd0, 5'd0, FN_MULTU);
         M_DIV:    enc_word = r_word(rs, rt, 5'd0, 5'd0, FN_DIV);
         M_DIVU:   enc_word = r_word(rs, rt, 5'd0, 5'd0, FN_DIVU);
         M_ADDI:   enc_word = i_word(OP_ADDI, rs, rt, imm);
         M_ADDIU:  enc_word = i_word(OP_ADDIU, rs, rt, imm);
         M_ANDI:   enc_word = i_word(OP_ANDI, rs, rt, imm);
         M_ORI:    enc_word = i_word(OP_ORI, rs, rt, imm);
         M_XORI:   enc_word = i_word(OP_XORI, rs, rt, imm);
         M_SLTI:   enc_word = i_word(OP_SLTI, rs, rt, imm);
         M_SLTIU:  enc_word = i_word(OP_SLTIU, rs, rt, imm);
         M_LUI:    enc_word = i_word(OP_LUI, 5'd0, rt, imm);
         M_LB:     enc_word = i_word(OP_LB, rs, rt, imm);
         M_LBU:    enc_word = i_word(OP_LBU, rs, rt, imm);
         M_LH:     enc_word = i_word(OP_LH, rs, rt, imm);
         M_LHU:    enc_word = i_word(OP_LHU, rs, rt, imm);
         M_LW:     enc_word = i_word(OP_LW, rs, rt, imm);
         M_SB:     enc_word = i_word(OP_SB, rs, rt, imm);
         M_SH:     enc_word = i_word(OP_SH, rs, rt, imm);
         M_SW:     enc_word = i_word(OP_SW, rs, rt, imm);
         M_BEQ:    enc_word = i_word(OP_BEQ, rs, rt, imm);
         M_BNE:    enc_word = i_word(OP_BNE, rs, rt, imm);
         M_BLEZ:   enc_word = i_word(OP_BLEZ, rs, 5'd0, imm);
         M_BGTZ:   enc_word = i_word(OP_BGTZ, rs, 5'd0, imm);
         M_BLTZ:   enc_word = i_word(OP_REGIMM, rs, RT_BLTZ, imm);
         M_BGEZ:   enc_word = i_word(OP_REGIMM, rs, RT_BGEZ, imm);
         M_BLTZAL: enc_word = i_word(OP_REGIMM, rs, RT_BLTZAL, imm);
         M_BGEZAL: enc_word = i_word(OP_REGIMM, rs, RT_BGEZAL, imm);
         M_J:      enc_word = j_word(OP_J, bus.in_target);
         M_JAL:    enc_word = j_word(OP_JAL, bus.in_target);
         default:  enc_legal = 1'b0;
      endcase
   end

   // Address: load_base wins over the increment, so a coinciding write still used the old address
   always_comb begin
      addr_d = addr_q;
      if (load_base)                  addr_d = base_addr;
      else if (pop)                   addr_d = addr_q + 1'b1;
      illegal_d = illegal_q;
      if (accept & ~enc_legal & (illegal_q != 8'hFF)) illegal_d = illegal_q + 8'd1;
   end

   // Address counter and saturating illegal-mnemonic counter
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         addr_q    <= '0;
         illegal_q <= '0;
      end else begin
         addr_q    <= addr_d;
         illegal_q <= illegal_d;
      end
   end

   instr_fifo #(
      .W     (32),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk        (clk),
      .reset_n    (reset_n),
      .push_i     (push),
      .push_dat_i (enc_word),
      .pop_i      (pop),
      .pop_dat_o  (head_dat),
      .full_o     (fifo_full),
      .empty_o    (fifo_empty)
   );

endmodule

// File: tb/tb_instruction_encoder.sv
// Scoreboard bench for instruction_encoder: expected words queued at accept, checked at each imem write.
// A small address model tracks load_base and write completions independently of the DUT.
// Stalled writes are checked for stable data/address on every held cycle.
module tb_instruction_encoder;
   import instruction_encoder_pkg::*;

   localparam int AW    = 10;
   localparam int DEPTH = 4;

   logic          clk;
   logic          reset_n;
   logic          load_base;
   logic [AW-1:0] base_addr;
   logic [7:0]    illegal_cnt;
   logic          idle;

   instruction_encoder_if #(.AW(AW)) bus ();

   instruction_encoder #(.AW(AW), .DEPTH(DEPTH)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .bus         (bus),
      .load_base   (load_base),
      .base_addr   (base_addr),
      .illegal_cnt (illegal_cnt),
      .idle        (idle)
   );

   int            n_tests = 0;
   int            n_fail  = 0;
   logic [31:0]   exp_q [$];
   logic [AW-1:0] model_addr = '0;
   logic          stall_v = 1'b0;
   logic [31:0]   stall_dat;
   logic [AW-1:0] stall_addr;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Write monitor on the falling edge: scoreboard pop, address model, stall stability
   always @(negedge clk) begin
      if (!reset_n) begin
         model_addr = '0;
         stall_v    = 1'b0;
      end else begin
         if (stall_v) begin
            check("stall_we", bus.imem_we, 1);
            check("stall_dat", bus.imem_wdata, stall_dat);
            check("stall_addr", bus.imem_addr, stall_addr);
         end
         if (bus.imem_we && bus.imem_ready) begin
            if (exp_q.size() == 0) check("unexpected_write", bus.imem_wdata, 0);
            else begin
               check("wdata", bus.imem_wdata, exp_q.pop_front());
               check("waddr", bus.imem_addr, model_addr);
            end
         end
         stall_v    = bus.imem_we && !bus.imem_ready;
         stall_dat  = bus.imem_wdata;
         stall_addr = bus.imem_addr;
         if (load_base)                          model_addr = base_addr;
         else if (bus.imem_we && bus.imem_ready) model_addr = model_addr + 1'b1;
      end
   end

   task automatic send(input logic [5:0] m, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [4:0] sh, input logic [15:0] imm,
                       input logic [25:0] tgt, input logic legal, input logic [31:0] w);
      int t = 0;
      bus.in_valid = 1'b1; bus.in_mnem = m; bus.in_rs = rs; bus.in_rt = rt; bus.in_rd = rd;
      bus.in_shamt = sh; bus.in_imm = imm; bus.in_target = tgt;
      while (!bus.in_ready && t < 100) begin
         @(posedge clk); #1;
         t++;
      end
      if (!bus.in_ready) begin
         check("send_timeout", 0, 1);
         bus.in_valid = 1'b0;
         return;
      end
      if (legal) exp_q.push_back(w);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic send_addiu(input int i);
      send(M_ADDIU, 5'd0, 5'(i), 5'd0, 5'd0, 16'(16 + i), 26'd0, 1'b1,
           32'h2400_0000 | (32'(i) << 16) | 32'(16 + i));
   endtask

   task automatic wait_drain();
      int t = 0;
      while ((exp_q.size() != 0 || !idle) && t < 200) begin
         @(posedge clk); #1;
         t++;
      end
      check("drain", (exp_q.size() == 0) && idle, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      reset_n = 1'b0; load_base = 1'b0; base_addr = '0;
      bus.in_valid = 1'b0; bus.in_mnem = '0; bus.in_rs = '0; bus.in_rt = '0; bus.in_rd = '0;
      bus.in_shamt = '0; bus.in_imm = '0; bus.in_target = '0; bus.imem_ready = 1'b1;
      #12;
      check("rst_we", bus.imem_we, 0);
      check("rst_addr", bus.imem_addr, 0);
      check("rst_wdata", bus.imem_wdata, 0);
      check("rst_illegal", illegal_cnt, 0);
      check("rst_idle", idle, 1);
      @(posedge clk); #1 reset_n = 1'b1;
      @(posedge clk); #1;
      check("rdy_after_rst", bus.in_ready, 1);

      // Single words, latency of one cycle
      send(M_ADD, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b1, 32'h0022_1820);
      check("lat_we", bus.imem_we, 1);
      check("lat_addr", bus.imem_addr, 0);
      check("lat_dat", bus.imem_wdata, 32'h0022_1820);
      send(M_ADDI, 5'd0, 5'd8, 5'd0, 5'd0, 16'h0005, 26'h0, 1'b1, 32'h2008_0005);
      check("addi_addr", bus.imem_addr, 1);
      check("addi_dat", bus.imem_wdata, 32'h2008_0005);

      // Forced fields
      send(M_SLL, 5'd7, 5'd1, 5'd2, 5'd4, 16'h0, 26'h0, 1'b1, 32'h0001_1100);
      send(M_BGEZAL, 5'd4, 5'd9, 5'd0, 5'd0, 16'hFFFE, 26'h0, 1'b1, 32'h0491_FFFE);
      send(M_J, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h100, 1'b1, 32'h0800_0100);
      send(M_MULT, 5'd3, 5'd4, 5'd9, 5'd5, 16'h0, 26'h0, 1'b1, 32'h0064_0018);
      send(M_LUI, 5'd7, 5'd5, 5'd0, 5'd0, 16'h1234, 26'h0, 1'b1, 32'h3C05_1234);
      send(M_BLEZ, 5'd2, 5'd3, 5'd0, 5'd0, 16'h0008, 26'h0, 1'b1, 32'h1840_0008);
      send(M_SW, 5'd29, 5'd31, 5'd0, 5'd0, 16'h0004, 26'h0, 1'b1, 32'hAFBF_0004);
      send(M_SRAV, 5'd3, 5'd2, 5'd1, 5'd7, 16'h0, 26'h0, 1'b1, 32'h0062_0807);
      send(M_BLTZ, 5'd1, 5'd5, 5'd0, 5'd0, 16'h0003, 26'h0, 1'b1, 32'h0420_0003);
      wait_drain();

      // Backpressure: DEPTH+2 requests against a stalled memory
      bus.imem_ready = 1'b0;
      for (int i = 0; i < DEPTH; i++) send_addiu(i);
      check("bp_full_rdy", bus.in_ready, 0);
      check("bp_idle", idle, 0);
      repeat (3) @(posedge clk);
      #1 check("bp_still_full", bus.in_ready, 0);
      fork
         begin
            for (int i = DEPTH; i < DEPTH + 2; i++) send_addiu(i);
         end
         begin
            repeat (4) @(posedge clk);
            #1 bus.imem_ready = 1'b1;
         end
      join
      wait_drain();

      // Illegal mnemonic and saturation
      send(6'd50, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0, 1'b0, 32'h0);
      repeat (2) @(posedge clk);
      #1;
      check("ill_cnt1", illegal_cnt, 1);
      check("ill_no_we", bus.imem_we, 0);
      for (int i = 0; i < 300; i++)
         send(6'(46 + i % 18), 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0, 1'b0, 32'h0);
      @(posedge clk); #1;
      check("ill_sat", illegal_cnt, 255);

      // Base load at the top of the address space, then wrap
      load_base = 1'b1; base_addr = 10'h3FF;
      @(posedge clk); #1 load_base = 1'b0;
      check("lb_addr", bus.imem_addr, 10'h3FF);
      send(M_OR, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b1, 32'h0022_1825);
      send(M_BNE, 5'd1, 5'd2, 5'd0, 5'd0, 16'h0010, 26'h0, 1'b1, 32'h1422_0010);
      wait_drain();
      check("wrap_addr", bus.imem_addr, 1);

      // load_base coinciding with a completing write
      bus.imem_ready = 1'b0;
      send(M_JAL, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h3FF_FFFF, 1'b1, 32'h0FFF_FFFF);
      send(M_ADDU, 5'd1, 5'd1, 5'd1, 5'd0, 16'h0, 26'h0, 1'b1, 32'h0021_0821);
      check("co_addr_pre", bus.imem_addr, 1);
      bus.imem_ready = 1'b1; load_base = 1'b1; base_addr = 10'd100;
      @(posedge clk); #1 load_base = 1'b0;
      check("co_addr_post", bus.imem_addr, 100);
      wait_drain();
      check("co_addr_end", bus.imem_addr, 101);

      // Reset with words queued
      bus.imem_ready = 1'b0;
      for (int i = 0; i < 3; i++) send_addiu(i);
      check("mid_idle", idle, 0);
      reset_n = 1'b0;
      #1;
      check("mid_rst_we", bus.imem_we, 0);
      check("mid_rst_addr", bus.imem_addr, 0);
      check("mid_rst_illegal", illegal_cnt, 0);
      check("mid_rst_idle", idle, 1);
      exp_q.delete();
      bus.imem_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      check("post_rst_we", bus.imem_we, 0);
      check("post_rst_addr", bus.imem_addr, 0);
      send(M_XOR, 5'd4, 5'd5, 5'd6, 5'd0, 16'h0, 26'h0, 1'b1, 32'h0085_3026);
      wait_drain();
      check("post_rst_next", bus.imem_addr, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
